// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: instruction encodings,
// controller states and the signedness decode.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration's arithmetic: a (WIDTH+1)-bit add (multiply) or subtract
// (restoring divide). cout is the carry for an add and the borrow for a subtract.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   res,
    output logic             cout
);

    logic [WIDTH+1:0] full;

    always_comb begin
        if (sub) full = {1'b0, a} - {2'b00, b};
        else     full = {1'b0, a} + {2'b00, b};
    end

    assign res  = full[WIDTH:0];
    assign cout = full[WIDTH+1];

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller with HI/LO registers: WIDTH shift-add or
// shift-subtract steps on operand magnitudes, then one sign-fixup cycle.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;

    // acc_q: product high half / partial remainder.
    // shf_q: multiplier shifting out / dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0]   acc_q, shf_q, opnd_q;
    logic               is_div_q, neg_q, neg_r, dz_q;

    op_e                op_sel;
    logic               sgn, launch;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    logic [WIDTH:0]     step_a, step_res, mul_sum;
    logic               step_sub, step_cout, div_ge;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    assign op_sel = op_e'(op);
    assign sgn    = is_signed_op(op_sel);
    assign rs_mag = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_mag = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign launch = (state == ST_IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (start) state_nxt = op[1] ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: if (cnt == LAST) state_nxt = ST_FIX;
            ST_FIX:         state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        stall = busy && (rd_hilo || start);
    end

    always_ff @(posedge clk) begin
        if (rst)                                    cnt <= '0;
        else if (launch || state == ST_FIX)         cnt <= '0;
        else if (state == ST_MUL || state == ST_DIV) cnt <= cnt + 1'b1;
    end

    // Divide shifts the next dividend bit into the remainder before subtracting.
    always_comb begin
        step_sub = (state == ST_DIV);
        step_a   = step_sub ? {acc_q, shf_q[WIDTH-1]} : {1'b0, acc_q};
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .a    (step_a),
        .b    (opnd_q),
        .sub  (step_sub),
        .res  (step_res),
        .cout (step_cout)
    );

    assign mul_sum = shf_q[0] ? step_res : {1'b0, acc_q};
    assign div_ge  = ~step_cout;

    // NOTE: the operand/iteration registers carry no reset; state returns to IDLE
    // on reset and every launch loads them before they are used.
    always_ff @(posedge clk) begin
        if (launch) begin
            acc_q    <= '0;
            shf_q    <= op[1] ? rs_mag : rt_mag;
            opnd_q   <= op[1] ? rt_mag : rs_mag;
            is_div_q <= op[1];
            neg_q    <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r    <= sgn && rs_data[WIDTH-1];
            dz_q     <= op[1] && (rt_data == '0);
        end else if (state == ST_MUL) begin
            acc_q <= mul_sum[WIDTH:1];
            shf_q <= {mul_sum[0], shf_q[WIDTH-1:1]};
        end else if (state == ST_DIV) begin
            acc_q <= div_ge ? step_res[WIDTH-1:0] : step_a[WIDTH-1:0];
            shf_q <= {shf_q[WIDTH-2:0], div_ge};
        end
    end

    // A zero divisor leaves the untouched dividend magnitude in acc_q, so the
    // remainder sign fix restores the original rs_data without extra storage.
    always_comb begin
        prod     = {acc_q, shf_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = dz_q ? '1 : (neg_q ? -shf_q : shf_q);
        rem_fix  = neg_r ? -acc_q : acc_q;
        res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (state == ST_FIX);
            div_by_zero <= (state == ST_FIX) && dz_q;
            if (state == ST_FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == ST_IDLE && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO/div_by_zero are queued at issue
// and popped when done pulses.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we, rd_hilo;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic [31:0] hi, lo;
    logic        busy, stall, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .rd_hilo     (rd_hilo),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: full-width arithmetic plus the corner-case rules.
    function automatic exp_t model(input string tag, input logic [1:0] o,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sbv;
        e.tag = tag;
        e.dz  = 1'b0;
        sa    = a;
        sbv   = b;
        if (o == OP_MULT) begin
            sp = 64'(sa) * 64'(sbv);
            {e.hi, e.lo} = sp;
        end else if (o == OP_MULTU) begin
            up = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = up;
        end else if (b == 32'h0) begin
            e.dz = 1'b1;
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'h0;
            e.lo = 32'h8000_0000;
        end else if (o == OP_DIV) begin
            e.lo = sa / sbv;
            e.hi = sa % sbv;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] h, input logic [31:0] l, input logic dz);
        exp_t e;
        e.tag = tag;
        e.hi  = h;
        e.lo  = l;
        e.dz  = dz;
        sb.push_back(e);
    endtask

    // Drives start for exactly one rising edge; returns at the negedge after it.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic compare_result(input int n, input logic seen);
        exp_t e;
        check("done_seen", 64'(seen), 64'd1);
        if (seen && sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, 64'(n), 64'd33);
            check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({e.tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
            check({e.tag, "_busy_done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic wait_done();
        int   n = 0;
        logic seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done;
        end
        compare_result(n, seen);
    endtask

    initial begin
        exp_t e;
        int   n;
        logic seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_hilo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);

        push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy", 64'(busy), 64'd1);
        wait_done();

        push_exp("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done();

        push_exp("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();

        push_exp("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done();
        check("divu_zero_done_pulse", 64'(done), 64'd1);

        push_exp("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();

        push_exp("div_zero_signed", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV, 32'hFFFF_FF00, 32'd0);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'($urandom_range(1, 300)) : $urandom;
            e  = model("rand", ro, ra, rb);
            sb.push_back(e);
            issue(ro, ra, rb);
            wait_done();
        end

        // Stall with rd_hilo, plus ignored start/MTHI/MTLO while busy.
        sb.push_back(model("stall_divu", OP_DIVU, 32'd1000, 32'd7));
        issue(OP_DIVU, 32'd1000, 32'd7);
        n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            if (n == 1) rd_hilo = 1'b1;
            if (n == 5) begin
                start = 1'b1; op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd5;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            #1;
            if (n >= 1 && (n % 8 == 1 || n == 5 || n == 32)) check("stall_busy", 64'(stall), 64'd1);
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done;
        end
        check("stall_done_cycle", 64'(stall), 64'd0);
        compare_result(n, seen);
        rd_hilo = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored_start_idle", 64'(busy), 64'd0);
        check("hold_hi", 64'(hi), 64'd6);
        check("hold_lo", 64'(lo), 64'd142);

        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", 64'(hi), 64'hA5A5_5A5A);
        check("mt_both_lo", 64'(lo), 64'hA5A5_5A5A);

        // Reset at iteration 10 aborts without a late done.
        issue(OP_MULTU, 32'h1234_5678, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi", 64'(hi), 64'd0);

        push_exp("start_wins", 32'h0, 32'd6, 1'b0);
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3;
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("start_wins_hi", 64'(hi), 64'd0);
        check("start_wins_busy", 64'(busy), 64'd1);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; even values of 8 or more are supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a multiply/divide instruction in EX, sampled each edge.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports rs_data and rt_data, inputs, WIDTH bits each: multiplicand/dividend (rs) and multiplier/divisor (rt).
REQ-007 The block SHALL have ports hi_we and lo_we, inputs, 1 bit each: MTHI/MTLO write enables.
REQ-008 The block SHALL have port wdata, input, WIDTH bits: MTHI/MTLO data.
REQ-009 The block SHALL have port rd_hilo, input, 1 bit: MFHI/MFLO in EX.
REQ-010 The block SHALL have ports hi and lo, outputs, WIDTH bits each: the HI/LO registers.
REQ-011 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-012 The block SHALL have port stall, output, 1 bit: pipeline freeze request.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are updated by an operation.
REQ-014 The block SHALL have port div_by_zero, output, 1 bit: one-cycle pulse coincident with done for a divide with rt_data = 0.

Function
REQ-015 States SHALL be IDLE, MUL, DIV, FIX.
REQ-016 In IDLE, start=1 at edge k SHALL latch the operands and op and enter MUL (op[1]=0) or DIV (op[1]=1), with iteration counter = 0.
REQ-017 Signed ops SHALL latch the operand magnitudes and record the quotient/product sign (sign(rs) XOR sign(rt)) and the remainder sign (sign(rs)).
REQ-018 MUL SHALL perform one shift-add step per edge for WIDTH edges (k+1..k+WIDTH), then enter FIX.
REQ-019 DIV SHALL perform one restoring shift-subtract step per edge for WIDTH edges, then enter FIX.
REQ-020 FIX at edge k+WIDTH+1 SHALL apply sign correction, write hi/lo, assert done for the following cycle, and return to IDLE.
REQ-021 Fixed latency SHALL be WIDTH+1 edges from the start edge to the hi/lo update, independent of operand values.
REQ-022 Multiply results SHALL be hi = upper WIDTH bits and lo = lower WIDTH bits of the 2*WIDTH-bit product.
REQ-023 Divide results SHALL be lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-024 Divisor 0 (signed or unsigned) SHALL give lo = all ones, hi = original rs_data, and div_by_zero=1 with done; latency is unchanged.
REQ-025 Signed overflow (most-negative / -1) SHALL give lo = most-negative value and hi = 0.
REQ-026 busy SHALL be 1 in MUL, DIV and FIX, and 0 in IDLE.
REQ-027 stall SHALL equal busy AND (rd_hilo OR start).
REQ-028 start while busy SHALL be ignored; the in-flight operation is unaffected.
REQ-029 hi_we/lo_we in IDLE without start SHALL write wdata to hi/lo at the edge; both may be asserted together.
REQ-030 hi_we/lo_we while busy SHALL be ignored.
REQ-031 start and hi_we/lo_we together in IDLE: start SHALL win and the write is dropped.
REQ-032 hi/lo SHALL hold their values at all times except on an MTHI/MTLO write or a FIX update.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, hi=lo=0, busy=stall=done=div_by_zero=0, and counter=0, aborting any in-flight operation without updating hi/lo.
REQ-034 rst SHALL take priority over start and hi_we/lo_we at the same edge.

Structure
REQ-035 Shared package mdu_pkg SHALL hold the op encodings (MULT, MULTU, DIV, DIVU) and the state enumeration.
REQ-036 One sub-module, mdu_step, SHALL implement the WIDTH-bit add/subtract step shared by the MUL and DIV iterations.
REQ-037 All registers SHALL be in mdu_ctrl; mdu_step SHALL be purely combinational.

Verification
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the start edge.
REQ-039 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero and done pulse together.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no div_by_zero.
REQ-042 rd_hilo=1 held from 2 cycles after start -> stall=1 until FIX completes; stall=0 in the done cycle; lo then matches the expected result.
REQ-043 rst at iteration 10 -> next cycle busy=0 and hi=lo=0; a following MTLO of 0x1234 -> lo=0x1234; a start asserted with MTHI -> hi not written by MTHI.
